// File: rtl/cgol_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
package cgol_pkg;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        COMPUTE,
        COPY,
        HOLD
    } seq_state_t;

    localparam int ROWS = 8;

    localparam logic PREV_SEL_SEED = 1'b0;
    localparam logic PREV_SEL_CUR  = 1'b1;

endpackage

// File: rtl/hold_timer.sv
// Counts display-hold cycles; done is high on the last of HOLD_CYCLES enabled cycles.
module hold_timer #(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic ph1,
    input  logic reset,
    input  logic start,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (start)
            r_cnt <= '0;
        else if (en && !done)
            r_cnt <= r_cnt + 1'b1;
    end

    assign done = en && (r_cnt == LAST);

endmodule

// File: rtl/gen_sequencer.sv
// Generation sequencer: seed LOAD, then COMPUTE / COPY / HOLD per generation,
// plus display row scan and run/step/reload control.
module gen_sequencer
    import cgol_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REGBITS     = 3,
    parameter int HOLD_CYCLES = 1024,
    parameter int GENBITS     = 16
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               reload,
    input  logic               seed_valid,
    input  logic [WIDTH-1:0]   seed_row,
    output logic               seed_ready,
    output logic [REGBITS-1:0] addr,
    output logic               prev_we,
    output logic               cur_we,
    output logic               prev_wsel,
    output logic               disp_en,
    output logic [REGBITS-1:0] disp_addr,
    output logic [GENBITS-1:0] gen_count,
    output logic               busy
);

    localparam logic [REGBITS-1:0] LAST_ROW = '1;

    seq_state_t         r_state;
    logic [REGBITS-1:0] r_addr;
    logic [REGBITS-1:0] r_disp_addr;
    logic [GENBITS-1:0] r_gen;
    logic               w_xfer;
    logic               w_hold_start;
    logic               w_hold_done;
    logic               w_unused;

    // Row data goes straight to the register file; the sequencer only steers it.
    assign w_unused = ^seed_row;

    assign seed_ready   = reset && (r_state == LOAD);
    assign w_xfer       = seed_ready && seed_valid;
    assign prev_we      = w_xfer || (reset && (r_state == COPY));
    assign prev_wsel    = (r_state == COPY) ? PREV_SEL_CUR : PREV_SEL_SEED;
    assign cur_we       = reset && (r_state == COMPUTE);
    assign busy         = (r_state == COMPUTE) || (r_state == COPY) || (r_state == HOLD);
    assign disp_en      = (r_state == IDLE) || (r_state == HOLD);
    assign addr         = r_addr;
    assign disp_addr    = r_disp_addr;
    assign gen_count    = r_gen;
    assign w_hold_start = (r_state == COPY) && (r_addr == LAST_ROW);

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .ph1  (ph1),
        .reset(reset),
        .start(w_hold_start),
        .en   (r_state == HOLD),
        .done (w_hold_done)
    );

    // Row address wraps to 0 on its own after the last row of each sweep.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD;
            r_addr  <= '0;
            r_gen   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_xfer) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_addr == LAST_ROW)
                            r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (reload) begin
                        r_state <= LOAD;
                        r_addr  <= '0;
                        r_gen   <= '0;
                    end else if (run || step) begin
                        r_state <= COMPUTE;
                        r_addr  <= '0;
                    end
                end
                COMPUTE: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == LAST_ROW)
                        r_state <= COPY;
                end
                COPY: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == LAST_ROW) begin
                        r_state <= HOLD;
                        r_gen   <= r_gen + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_hold_done)
                        r_state <= IDLE;
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset)
            r_disp_addr <= '0;
        else if (disp_en)
            r_disp_addr <= r_disp_addr + 1'b1;
    end

endmodule

// File: tb/tb_gen_sequencer.sv
// Scoreboard bench for gen_sequencer: expected register-file writes and
// generation counts are queued at stimulus time and checked by monitors.
module tb_gen_sequencer;

    typedef struct {
        int kind;  // 0 seed write, 1 compute write, 2 copy write
        int addr;
        int data;
    } wr_t;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0, step = 1'b0, reload = 1'b0;
    logic        seed_valid = 1'b0;
    logic [7:0]  seed_row = 8'h00;
    logic        seed_ready, prev_we, cur_we, prev_wsel, disp_en, busy;
    logic [2:0]  addr, disp_addr;
    logic [15:0] gen_count;

    logic        run1 = 1'b0, step1 = 1'b0, reload1 = 1'b0;
    logic        sr1, pwe1, cwe1, psel1, den1, busy1;
    logic [2:0]  addr1, daddr1;
    logic [1:0]  gen1;

    int   n_vec = 0;
    int   n_err = 0;
    wr_t  sb[$];
    int   q1[$];
    int   starts[$];
    int   wraps = 0;

    always #5 ph1 = ~ph1;

    gen_sequencer dut (
        .ph1(ph1), .reset(reset), .run(run), .step(step), .reload(reload),
        .seed_valid(seed_valid), .seed_row(seed_row), .seed_ready(seed_ready),
        .addr(addr), .prev_we(prev_we), .cur_we(cur_we), .prev_wsel(prev_wsel),
        .disp_en(disp_en), .disp_addr(disp_addr), .gen_count(gen_count), .busy(busy)
    );

    gen_sequencer #(.HOLD_CYCLES(4), .GENBITS(2)) dut1 (
        .ph1(ph1), .reset(reset), .run(run1), .step(step1), .reload(reload1),
        .seed_valid(seed_valid), .seed_row(seed_row), .seed_ready(sr1),
        .addr(addr1), .prev_we(pwe1), .cur_we(cwe1), .prev_wsel(psel1),
        .disp_en(den1), .disp_addr(daddr1), .gen_count(gen1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic push_gen();
        for (int k = 1; k <= 2; k++)
            for (int r = 0; r < cgol_pkg::ROWS; r++)
                sb.push_back('{k, r, 0});
    endtask

    // One seed row per transfer; gap_after >= 0 inserts a 3-cycle stall there,
    // rnd adds random stalls and random data.
    task automatic load_seed(input int gap_after, input bit rnd);
        for (int i = 0; i < cgol_pkg::ROWS; i++) begin
            logic [7:0] d;
            if (rnd) begin
                repeat ($urandom_range(0, 2)) tick();
                d = 8'($urandom);
            end else
                d = 8'(1 << i);
            seed_valid = 1'b1;
            seed_row   = d;
            sb.push_back('{0, i, int'(d)});
            tick();
            seed_valid = 1'b0;
            if (i == gap_after)
                repeat (3) begin
                    @(negedge ph1);
                    chk("gap_addr_hold", addr, i + 1);
                    tick();
                end
        end
    endtask

    // Write monitor: every file write must match the head of the scoreboard.
    logic       p_ok = 1'b0, p_den = 1'b0;
    logic [2:0] p_daddr = '0;
    always @(negedge ph1) begin
        if (!reset) begin
            chk("write_in_reset", {30'd0, prev_we, cur_we}, 0);
        end else begin
            if (prev_we && cur_we)
                chk("write_overlap", 1, 0);
            if (prev_we || cur_we) begin
                if (sb.size() == 0)
                    chk("unexpected_write", 0, 1);
                else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("write_kind", cur_we ? 1 : (prev_wsel ? 2 : 0), e.kind);
                    chk("write_addr", addr, e.addr);
                    if (e.kind == 0)
                        chk("seed_data", seed_row, e.data);
                end
            end
            chk("disp_en", disp_en, !seed_ready && !cur_we && !(prev_we && prev_wsel));
            if (p_ok) begin
                chk("disp_addr", disp_addr, p_den ? 3'(p_daddr + 3'd1) : p_daddr);
                if (p_den && p_daddr == 3'd7) wraps++;
            end
        end
        p_ok    <= reset;
        p_den   <= disp_en;
        p_daddr <= disp_addr;
    end

    // Small-counter instance: each generation-count change must match the model.
    logic [1:0] p_gen1 = '0;
    logic       p_ok1 = 1'b0;
    always @(negedge ph1) begin
        if (reset && p_ok1 && gen1 != p_gen1) begin
            if (q1.size() == 0)
                chk("gen_wrap_extra", 0, 1);
            else
                chk("gen_wrap", gen1, q1.pop_front());
        end
        p_ok1  <= reset;
        p_gen1 <= gen1;
    end

    initial begin
        int cnt;
        int cyc;
        int g4;
        @(negedge ph1);
        chk("rst_seed_ready", seed_ready, 0);
        chk("rst_prev_we", prev_we, 0);
        chk("rst_cur_we", cur_we, 0);
        chk("rst_disp_en", disp_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        chk("rst_disp_addr", disp_addr, 0);
        chk("rst_gen", gen_count, 0);
        tick();
        reset = 1'b1;

        load_seed(2, 1'b0);
        chk("load_idle_ready", seed_ready, 0);
        chk("load_idle_busy", busy, 0);
        chk("load_gen", gen_count, 0);

        // Single step with ignored steps inside COMPUTE and HOLD.
        push_gen();
        step = 1'b1;
        tick();
        step = 1'b0;
        cnt = 0;
        while (busy && cnt < 3000) begin
            cnt++;
            step = (cnt == 3 || cnt == 500);
            tick();
        end
        step = 1'b0;
        chk("step_busy_cycles", cnt, 1040);
        chk("step_gen", gen_count, 1);
        repeat (20) tick();
        chk("step_no_extra", busy, 0);
        chk("step_gen_after", gen_count, 1);

        // Reload wins over step in the same IDLE cycle.
        reload = 1'b1;
        step   = 1'b1;
        tick();
        reload = 1'b0;
        step   = 1'b0;
        chk("reload_ready", seed_ready, 1);
        chk("reload_gen", gen_count, 0);
        chk("reload_busy", busy, 0);
        load_seed(-1, 1'b1);

        // Continuous run; the small instance runs five generations alongside.
        for (int g = 0; g < 4; g++) push_gen();
        for (int k = 1; k <= 5; k++) q1.push_back(k % 4);
        run  = 1'b1;
        run1 = 1'b1;
        cyc  = 0;
        g4   = -1;
        begin
            logic last_cur;
            last_cur = 1'b0;
            while (cyc < 6000) begin
                tick();
                cyc++;
                if (cur_we && !last_cur) begin
                    starts.push_back(cyc);
                    if (starts.size() == 4) g4 = gen_count;
                end
                last_cur = cur_we;
                if (q1.size() == 0) run1 = 1'b0;
                if (starts.size() == 4 && prev_we && prev_wsel) break;
            end
        end
        run = 1'b0;
        chk("run_timeout", cyc < 6000, 1);
        chk("run_starts", starts.size(), 4);
        for (int s = 1; s < starts.size(); s++)
            chk("run_period", starts[s] - starts[s-1], 1041);
        chk("run_gen3", g4, 3);
        cnt = 0;
        while (busy && cnt < 2000) begin cnt++; tick(); end
        repeat (30) tick();
        chk("stop_busy", busy, 0);
        chk("stop_gen4", gen_count, 4);
        chk("stop_disp_en", disp_en, 1);
        chk("wrap_queue_empty", q1.size(), 0);
        chk("wrap_idle", busy1, 0);

        // Asynchronous reset in the middle of COMPUTE.
        push_gen();
        step = 1'b1;
        tick();
        step = 1'b0;
        cnt = 0;
        while (!(cur_we && addr == 3'd4) && cnt < 50) begin cnt++; tick(); end
        chk("mid_reach_addr4", cnt < 50, 1);
        reset = 1'b0;
        seed_valid = 1'b1;
        #1;
        chk("mid_cur_we", cur_we, 0);
        chk("mid_prev_we", prev_we, 0);
        sb.delete();
        repeat (2) tick();
        seed_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_seed_ready", seed_ready, 1);
        chk("mid_addr", addr, 0);
        chk("mid_gen", gen_count, 0);
        chk("mid_busy", busy, 0);

        repeat (5) tick();
        chk("sb_drained", sb.size(), 0);
        chk("disp_wrap_seen", wraps > 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gen_sequencer.md
Name: gen_sequencer

Overview:
- Generation sequencer for the 8x8 Game-of-Life datapath.
- Loads a seed pattern into the prev_state register file, then steps the datapath one generation at a time:
  - COMPUTE: read prev rows, write new rows to current_state.
  - COPY: current_state back to prev_state.
  - HOLD: display time.
- Also drives the display row-scan address and exposes run/step/reload control.

Parameters:
- WIDTH, 8, bits per row (columns of the grid).
- REGBITS, 3, row address width; ROWS = 2**REGBITS = 8.
- HOLD_CYCLES, 1024, cycles spent in HOLD per generation (>=1).
- GENBITS, 16, width of the generation counter.

Ports:
- ph1  in  1  single clock, rising-edge active.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- run  in  1  level; free-running generations while 1.
- step  in  1  one-cycle pulse; single generation, sampled only in IDLE.
- reload  in  1  one-cycle pulse; re-enter seed LOAD, sampled only in IDLE.
- seed_valid  in  1  seed row present.
- seed_row  in  WIDTH  seed row data.
- seed_ready  out  1  block accepts a seed row.
- addr  out  REGBITS  shared register-file row address.
- prev_we  out  1  write enable, prev_state file.
- cur_we  out  1  write enable, current_state file.
- prev_wsel  out  1  prev_state write mux: 0 = seed_row, 1 = current_state readback.
- disp_en  out  1  display scanning enabled.
- disp_addr  out  REGBITS  display row being scanned.
- gen_count  out  GENBITS  completed generations since last LOAD.
- busy  out  1  generation in progress (COMPUTE, COPY or HOLD).

Behaviour:
- States: LOAD, IDLE, COMPUTE, COPY, HOLD.
- Reset (reset=0, asynchronous):
  - state=LOAD, addr=0, disp_addr=0, gen_count=0, hold counter=0.
  - seed_ready=0, prev_we=0, cur_we=0, prev_wsel=0, disp_en=0, busy=0.
  - All strobes are gated by reset=1, so no file write can occur while reset is held and ph1 toggles.
- LOAD:
  - seed_ready=1.
  - Handshake: a transfer occurs on an edge where seed_valid&seed_ready. That cycle prev_we=1, prev_wsel=0, and seed_row is written at addr.
  - addr increments per transfer. The transfer at addr=ROWS-1 moves to IDLE with addr=0.
  - seed_valid low stalls with addr held; there is no timeout.
  - Entering LOAD clears gen_count.
- IDLE:
  - disp_en=1.
  - Priority: reload > (run | step).
  - reload -> LOAD with addr=0. run=1 or step=1 -> COMPUTE with addr=0.
  - step outside IDLE is ignored (not queued).
- COMPUTE:
  - cur_we=1 every cycle; addr sweeps 0..ROWS-1, exactly ROWS cycles.
  - The datapath forms new row[addr] combinationally from prev rows addr-1, addr, addr+1 with toroidal wrap. The sequencer only presents addr.
  - At addr=ROWS-1 -> COPY, addr=0.
- COPY:
  - prev_we=1, prev_wsel=1; addr sweeps 0..ROWS-1, exactly ROWS cycles.
  - At addr=ROWS-1: gen_count increments (wraps modulo 2**GENBITS), -> HOLD, hold counter=0.
- HOLD:
  - disp_en=1; counts HOLD_CYCLES cycles.
  - On the last cycle -> IDLE. If run is still 1 in IDLE, COMPUTE starts the next cycle.
- Generation period with run held: 1 (IDLE) + ROWS + ROWS + HOLD_CYCLES = 1041 cycles at defaults.
- Display scan: disp_addr increments (wrapping ROWS-1 -> 0) every cycle disp_en=1; it holds during LOAD, COMPUTE and COPY.
- busy=1 exactly in COMPUTE, COPY and HOLD.
- run dropped mid-generation: the generation completes through HOLD, then the block stays in IDLE.
- All outputs except seed_ready, prev_we and prev_wsel are registered or state-decoded. prev_we in LOAD is combinational from the handshake.
- Reset mid-operation: immediate return to LOAD state. The generation is abandoned; the file contents are don't-care until reseeded.

Decomposition:
- Package cgol_pkg:
  - enum seq_state_t {LOAD, IDLE, COMPUTE, COPY, HOLD}.
  - localparam ROWS.
  - PREV_SEL_SEED=0, PREV_SEL_CUR=1.
- One sub-module: hold_timer.
  - Parameterised by HOLD_CYCLES; ports start and done.
  - Internal counter width $clog2(HOLD_CYCLES+1).
- The FSM, address counter and display counter stay in gen_sequencer.

Test Plan:
- Seed load with gaps:
  - Stimulus: reset pulse, then 8 seed rows 8'h01..8'h80 with seed_valid dropped for 3 cycles after row 2.
  - Required: exactly 8 prev_we pulses at addr 0..7 with the matching data; addr holds during the gap; IDLE reached; gen_count=0.
- Single step:
  - Stimulus: one step pulse in IDLE.
  - Required: 8 cycles of cur_we (addr 0..7), then 8 cycles of prev_we with prev_wsel=1, then 1024 HOLD cycles, then IDLE; gen_count=1; busy high for 1040 cycles.
- Continuous run:
  - Stimulus: run held for 3 generations.
  - Required: COMPUTE starts are 1041 cycles apart; gen_count reaches 3.
  - Stimulus: run dropped during COPY of generation 4.
  - Required: generation 4 completes, gen_count=4, block stays in IDLE.
- Ignored and priority controls:
  - Stimulus: step pulses during COMPUTE and HOLD.
  - Required: no extra generation.
  - Stimulus: reload and step in the same IDLE cycle.
  - Required: LOAD entered, gen_count cleared to 0.
- Async reset mid-COMPUTE:
  - Stimulus: reset=0 asserted at addr=4, held 2 cycles with ph1 toggling.
  - Required: cur_we=0 immediately, no writes while held, state=LOAD, seed_ready=1 after release.
- Counter wrap:
  - Stimulus: GENBITS=2, HOLD_CYCLES=4, run held for 5 generations.
  - Required: gen_count sequence 1,2,3,0,1.
  - Required: disp_addr advances only in IDLE/HOLD and wraps 7 -> 0.
